// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the registered stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requesting channel above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_CH = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    int unsigned target;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        target      = 0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            target = (32'(ptr) + off) % N_CH;
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!grant_valid && k == target && req[k]) begin
                    grant       = SEL_W'(k);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream mux with explicit select or packet-granular round-robin.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_CH*WIDTH-1:0]   i_data,
    input  logic [N_CH-1:0]         i_valid,
    input  logic [N_CH-1:0]         i_last,
    output logic [N_CH-1:0]         o_ready,
    input  logic                    i_mode,
    input  logic [SEL_W-1:0]        i_ctrl,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    output logic                    o_last,
    output logic [SEL_W-1:0]        o_chan
);

    state_t           state;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_gnt;
    logic             rr_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             can_load;
    logic             in_xfer;
    logic             in_last;
    logic [WIDTH-1:0] in_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req         (i_valid),
        .ptr         (rr_ptr),
        .grant       (rr_gnt),
        .grant_valid (rr_vld)
    );

    // Grant source: frozen channel while a packet is in flight, else mode-dependent.
    always_comb begin
        grant     = lock_ch;
        grant_vld = 1'b1;
        if (state == ST_IDLE) begin
            case (i_mode)
                MODE_RR: begin
                    grant     = rr_gnt;
                    grant_vld = rr_vld;
                end
                MODE_SEL: begin
                    grant     = i_ctrl;
                    grant_vld = ({1'b0, i_ctrl} < (SEL_W+1)'(N_CH));
                end
                default: ;
            endcase
        end
    end

    assign can_load = ~o_valid | i_ready;

    // One-hot ready and the granted channel's beat.
    always_comb begin
        o_ready = '0;
        in_data = '0;
        in_last = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                o_ready[k] = i_rst_n & can_load & grant_vld;
                in_data    = i_data[k*WIDTH +: WIDTH];
                in_last    = i_last[k];
            end
        end
    end

    assign in_xfer = |(i_valid & o_ready);

    // Output register, packet lock and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
            rr_ptr  <= SEL_W'(N_CH - 1);
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_chan  <= '0;
        end else if (in_xfer) begin
            o_data  <= in_data;
            o_last  <= in_last;
            o_chan  <= grant;
            o_valid <= 1'b1;
            if (in_last) begin
                state  <= ST_IDLE;
                rr_ptr <= grant;
            end else begin
                state   <= ST_LOCKED;
                lock_ch <= grant;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed self-checking bench for stream_mux_arb (4-channel and 5-channel instances).
module tb_stream_mux_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] data4 = '0;
    logic [3:0]  valid4 = '0, last4 = '0, ready4;
    logic        mode4 = 1'b0, dready4 = 1'b1;
    logic [1:0]  ctrl4 = '0, ochan4;
    logic [15:0] odata4;
    logic        ovalid4, olast4;

    logic [79:0] data5 = '0;
    logic [4:0]  valid5 = '0, last5 = '0, ready5;
    logic        mode5 = 1'b0, dready5 = 1'b1;
    logic [2:0]  ctrl5 = '0, ochan5;
    logic [15:0] odata5;
    logic        ovalid5, olast5;

    int total = 0;
    int bad = 0;
    int cnt [4];
    int exp_ch;

    stream_mux_arb #(.N_CH(4), .WIDTH(16)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(valid4),
        .i_last(last4), .o_ready(ready4), .i_mode(mode4), .i_ctrl(ctrl4),
        .i_ready(dready4), .o_data(odata4), .o_valid(ovalid4),
        .o_last(olast4), .o_chan(ochan4)
    );

    stream_mux_arb #(.N_CH(5), .WIDTH(16)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data5), .i_valid(valid5),
        .i_last(last5), .o_ready(ready5), .i_mode(mode5), .i_ctrl(ctrl5),
        .i_ready(dready5), .o_data(odata5), .o_valid(ovalid5),
        .o_last(olast5), .o_chan(ochan5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // All four channels valid; each sends 2-beat packets tagged C0<ch><beat>.
    task automatic drive_rr();
        valid4 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            data4[k*16 +: 16] = {8'hC0, 4'(k), 4'(cnt[k])};
            last4[k] = (cnt[k] == 1);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        mode4 = 1'b0; ctrl4 = 2'd2; valid4 = 4'b0100; last4 = 4'b0100;
        data4[47:32] = 16'hBEEF;
        #3;
        chk("rst_valid", 32'(ovalid4), 32'h0);
        chk("rst_data", 32'(odata4), 32'h0);
        chk("rst_chan", 32'(ochan4), 32'h0);
        chk("rst_ready", 32'(ready4), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Mode 0 single beat from channel 2
        #1 chk("m0_ready", 32'(ready4), 32'b0100);
        cyc();
        chk("m0_valid", 32'(ovalid4), 32'h1);
        chk("m0_data", 32'(odata4), 32'hBEEF);
        chk("m0_chan", 32'(ochan4), 32'h2);
        chk("m0_last", 32'(olast4), 32'h1);
        valid4 = '0;
        cyc();
        chk("m0_drain", 32'(ovalid4), 32'h0);

        // Mode 0 lock: ch1 3-beat packet, ctrl moves to 3 mid-packet
        ctrl4 = 2'd1; valid4 = 4'b1010; last4 = 4'b1000;
        data4[63:48] = 16'h3333; data4[31:16] = 16'hA001;
        #1 chk("lk_ready1", 32'(ready4), 32'b0010);
        cyc();
        chk("lk_data1", 32'(odata4), 32'hA001);
        chk("lk_chan1", 32'(ochan4), 32'h1);
        ctrl4 = 2'd3; data4[31:16] = 16'hA002;
        #1 chk("lk_ready2", 32'(ready4), 32'b0010);
        cyc();
        chk("lk_data2", 32'(odata4), 32'hA002);
        chk("lk_chan2", 32'(ochan4), 32'h1);
        data4[31:16] = 16'hA003; last4 = 4'b1010;
        #1 chk("lk_ready3", 32'(ready4), 32'b0010);
        cyc();
        chk("lk_data3", 32'(odata4), 32'hA003);
        chk("lk_last3", 32'(olast4), 32'h1);
        valid4 = 4'b1000;
        #1 chk("lk_ready_ch3", 32'(ready4), 32'b1000);
        cyc();
        chk("lk_data_ch3", 32'(odata4), 32'h3333);
        chk("lk_chan_ch3", 32'(ochan4), 32'h3);
        valid4 = '0;
        cyc();

        // Mode 1 fairness: pointer sits at 3, so channel 0 leads
        mode4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rr();
            exp_ch = (i / 2) % 4;
            #1 chk("rr_ready", 32'(ready4), 32'(1 << exp_ch));
            cyc();
            chk("rr_valid", 32'(ovalid4), 32'h1);
            chk("rr_chan", 32'(ochan4), 32'(exp_ch));
            chk("rr_data", 32'(odata4), 32'({8'hC0, 4'(exp_ch), 4'(cnt[exp_ch])}));
            chk("rr_last", 32'(olast4), 32'(cnt[exp_ch] == 1));
            cnt[exp_ch] = (cnt[exp_ch] + 1) % 2;
        end

        // Backpressure on a ch1 beat
        drive_rr();
        #1 chk("bp_ready_in", 32'(ready4), 32'b0010);
        cyc();
        chk("bp_load", 32'(odata4), 32'hC010);
        cnt[1] = 1;
        dready4 = 1'b0;
        drive_rr();
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready_hold", 32'(ready4), 32'h0);
            cyc();
            chk("bp_data_hold", 32'(odata4), 32'hC010);
            chk("bp_valid_hold", 32'(ovalid4), 32'h1);
        end
        dready4 = 1'b1;
        #1 chk("bp_ready_rel", 32'(ready4), 32'b0010);
        cyc();
        chk("bp_next1", 32'(odata4), 32'hC011);
        chk("bp_next1_last", 32'(olast4), 32'h1);
        cnt[1] = 0;
        drive_rr();
        #1 chk("bp_ready_ch2", 32'(ready4), 32'b0100);
        cyc();
        chk("bp_next2", 32'(odata4), 32'hC020);
        chk("bp_next2_chan", 32'(ochan4), 32'h2);

        // Reset in the middle of ch2's packet
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(ovalid4), 32'h0);
        chk("mrst_data", 32'(odata4), 32'h0);
        chk("mrst_chan", 32'(ochan4), 32'h0);
        chk("mrst_ready", 32'(ready4), 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        drive_rr();
        #1 chk("mrst_ready_rr", 32'(ready4), 32'b0001);
        cyc();
        chk("mrst_first_chan", 32'(ochan4), 32'h0);
        chk("mrst_first_data", 32'(odata4), 32'hC000);
        valid4 = '0;

        // Invalid select on the 5-channel instance
        mode5 = 1'b0; valid5 = 5'b11111; last5 = 5'b11111;
        data5[79:64] = 16'h4444;
        ctrl5 = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1 chk("inv5_ready", 32'(ready5), 32'h0);
            cyc();
            chk("inv5_valid", 32'(ovalid5), 32'h0);
        end
        ctrl5 = 3'd7;
        for (int i = 0; i < 3; i++) begin
            #1 chk("inv7_ready", 32'(ready5), 32'h0);
            cyc();
            chk("inv7_valid", 32'(ovalid5), 32'h0);
        end
        ctrl5 = 3'd4;
        #1 chk("sel4_ready", 32'(ready5), 32'b10000);
        cyc();
        chk("sel4_valid", 32'(ovalid5), 32'h1);
        chk("sel4_chan", 32'(ochan5), 32'h4);
        chk("sel4_data", 32'(odata5), 32'h4444);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel registered stream multiplexer, the successor to the fixed 4×16-bit registered select mux. Each input channel carries a valid/ready/last stream. One channel is forwarded into a single output register. The channel is chosen either by an explicit select input or by packet-granular round-robin arbitration. It sits between multiple producer streams and a single downstream consumer that may apply backpressure.

## Interface
Parameters:
- N_CH, 4, number of input channels (≥2)
- WIDTH, 16, data width per channel
- SEL_W, $clog2(N_CH), derived select/channel-index width (localparam, not overridable)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_data  in  N_CH*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH]
- i_valid  in  N_CH  per-channel beat valid
- i_last  in  N_CH  per-channel end-of-packet flag
- o_ready  out  N_CH  per-channel ready
- i_mode  in  1  0 = explicit select, 1 = round-robin
- i_ctrl  in  SEL_W  channel select, used in mode 0
- i_ready  in  1  downstream ready
- o_data  out  WIDTH  registered output data
- o_valid  out  1  registered output valid
- o_last  out  1  registered end-of-packet
- o_chan  out  SEL_W  source channel of the current output beat

## Operation
- **Transfer definitions.**
  - Input transfer on channel k: i_valid[k] & o_ready[k].
  - Output transfer: o_valid & i_ready.
- **Load condition.** can_load = !o_valid | i_ready. This is a combinational path from i_ready to o_ready; it is intentional.
- **Ready.** o_ready[k] = can_load & (grant == k). At most one bit of o_ready is set.
- **Output register.**
  - On an input transfer: o_data/o_last/o_chan load that channel's beat, and o_valid is set.
  - On an output transfer with no input transfer: o_valid clears. o_data/o_last/o_chan hold their values.
- **Packet-lock FSM.**
  - IDLE: the grant is computed every cycle.
    - Mode 0: grant = i_ctrl. If i_ctrl ≥ N_CH, there is no grant and o_ready is 0.
    - Mode 1: grant = first channel with i_valid set, searching upward from rr_ptr+1 modulo N_CH. If no channel is valid, there is no grant and o_ready is 0.
  - IDLE→LOCKED: on an input transfer with i_last=0. The grant is frozen in a register.
  - LOCKED: the grant is the frozen channel. i_mode and i_ctrl are ignored.
  - LOCKED→IDLE: on an input transfer with i_last=1.
  - A single-beat packet (i_last=1 in IDLE) stays in IDLE.
- **Round-robin pointer.** rr_ptr ← granted channel on every input transfer with i_last=1, in either mode. The pointer therefore advances at packet granularity.
- **Reset (asynchronous, i_rst_n=0).**
  - o_valid=0, o_data=0, o_last=0, o_chan=0.
  - FSM=IDLE, rr_ptr=N_CH-1, so channel 0 has first priority.
  - o_ready is all 0 while in reset.
  - Reset mid-packet discards the lock and any held beat.

## Timing
- **Latency.** 1 cycle: an input transfer at edge t gives o_valid=1 after edge t.
- **Throughput.** One beat per cycle with i_ready held high. This includes back-to-back packets from different channels.
- **Backpressure.** While o_valid & !i_ready:
  - o_data/o_last/o_chan stay stable.
  - o_ready is all 0.
- **Simultaneous output and input transfer.** The register reloads; o_valid stays 1 with no bubble.
- **Arbitration hand-off.** A channel switch in mode 1 takes effect in the cycle after the last-beat transfer. There are no idle cycles if the next channel is valid.
- **i_ctrl changes in mode 0.** A change while IDLE takes effect the same cycle. A change while LOCKED is ignored until the packet ends.

## Structure
- **Package stream_mux_pkg:**
  - mode constants MODE_SEL=1'b0, MODE_RR=1'b1
  - FSM state enum {ST_IDLE, ST_LOCKED}
- **Sub-module rr_arbiter:**
  - parameter N_CH
  - combinational search
  - inputs: request vector, pointer
  - outputs: grant index and grant-valid

## Test plan
- **Reset.** Assert i_rst_n=0 mid-stream. Required: o_valid=0, o_data=0, o_chan=0 immediately; after release, channel 0 wins the first RR arbitration.
- **Mode 0 streaming.** N_CH=4, WIDTH=16, i_ctrl=2, i_data ch2=16'hBEEF single-beat, i_ready=1. Required: o_data=16'hBEEF, o_chan=2, o_valid=1 one cycle later, o_ready=4'b0100.
- **Mode 0 lock.** Ch1 sends a 3-beat packet (A1,A2,A3, last on A3); i_ctrl switches to 3 after beat A1. Required: all three beats come out from channel 1 with o_chan=1 before any ch3 data.
- **Mode 1 fairness.** All 4 channels continuously valid with 2-beat packets, i_ready=1. Required: output channel order 0,0,1,1,2,2,3,3,0,…, one beat per cycle with no bubbles.
- **Backpressure.** Hold i_ready=0 for 5 cycles with o_valid=1. Required: o_data stable and o_ready=0 throughout. On release, the held beat and the next beat transfer on consecutive cycles.
- **Invalid select.** Mode 0 with i_ctrl=5 on N_CH=5 (SEL_W=3) and i_ctrl=7. Required: o_ready=0 and o_valid never asserts.
